// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter
//   Two-master AHB-lite arbiter in front of the single memory slave.
//   Round-robin between the two masters. A losing (or stalled) address phase
//   is parked in a per-master pending slot and replayed later, with the
//   master's hready held low meanwhile. Responses are steered back using a
//   data-phase owner register.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mN_h*  (N=0,1)      master-side AHB-lite address/data/response signals
//   s_h*                slave-side AHB-lite signals; s_hmaster tags the owner
//                       of the current address phase
module ahb_mem_arbiter #(
    parameter int unsigned W_ADDR   = 32,
    parameter int unsigned W_DATA   = 32,
    parameter logic [7:0]  HMASTER0 = 8'h00,
    parameter logic [7:0]  HMASTER1 = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [W_ADDR-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic              m0_hexcl,
    input  logic [1:0]        m0_htrans,
    input  logic [2:0]        m0_hsize,
    input  logic [W_DATA-1:0] m0_hwdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    output logic              m0_hexokay,
    output logic [W_DATA-1:0] m0_hrdata,

    input  logic [W_ADDR-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic              m1_hexcl,
    input  logic [1:0]        m1_htrans,
    input  logic [2:0]        m1_hsize,
    input  logic [W_DATA-1:0] m1_hwdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic              m1_hexokay,
    output logic [W_DATA-1:0] m1_hrdata,

    output logic [W_ADDR-1:0] s_haddr,
    output logic              s_hwrite,
    output logic              s_hexcl,
    output logic [1:0]        s_htrans,
    output logic [2:0]        s_hsize,
    output logic [7:0]        s_hmaster,
    output logic [W_DATA-1:0] s_hwdata,
    output logic              s_hready,
    input  logic              s_hready_resp,
    input  logic              s_hresp,
    input  logic              s_hexokay,
    input  logic [W_DATA-1:0] s_hrdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    owner_e            down_q, down_d;
    logic              last_q, last_d;      // 1: master 1 won most recently
    logic [1:0]        pend_q, pend_d;
    logic [W_ADDR-1:0] paddr_q  [2];
    logic [W_ADDR-1:0] paddr_d  [2];
    logic [2:0]        psize_q  [2];
    logic [2:0]        psize_d  [2];
    logic [1:0]        pwrite_q, pwrite_d;
    logic [1:0]        pexcl_q, pexcl_d;

    logic [W_ADDR-1:0] haddr_in [2];
    logic [2:0]        hsize_in [2];
    logic [1:0]        hwrite_in, hexcl_in;
    logic [1:0]        hready_out, live, req, grant;
    logic              arb_en, sel;

    assign haddr_in[0] = m0_haddr;
    assign haddr_in[1] = m1_haddr;
    assign hsize_in[0] = m0_hsize;
    assign hsize_in[1] = m1_hsize;
    assign hwrite_in   = {m1_hwrite, m0_hwrite};
    assign hexcl_in    = {m1_hexcl, m0_hexcl};

    // A pending master is stalled; the data-phase owner sees the slave's ready.
    assign hready_out[0] = pend_q[0] ? 1'b0 : ((down_q == OWN_M0) ? s_hready_resp : 1'b1);
    assign hready_out[1] = pend_q[1] ? 1'b0 : ((down_q == OWN_M1) ? s_hready_resp : 1'b1);
    assign m0_hready     = hready_out[0];
    assign m1_hready     = hready_out[1];

    // NONSEQ and SEQ both request; SEQ is re-issued as NONSEQ downstream.
    assign live[0] = (m0_htrans == 2'b10 || m0_htrans == 2'b11) && hready_out[0];
    assign live[1] = (m1_htrans == 2'b10 || m1_htrans == 2'b11) && hready_out[1];
    assign req     = pend_q | live;
    assign arb_en  = s_hready_resp & rst_n;

    always_comb begin
        grant = 2'b00;
        if (arb_en) begin
            if (&req) grant = last_q ? 2'b01 : 2'b10;
            else      grant = req;
        end
    end

    // Winner's fields come from its pending slot if parked, else straight through.
    always_comb begin
        sel       = grant[1];
        s_htrans  = (|grant) ? 2'b10 : 2'b00;
        s_hmaster = sel ? HMASTER1 : HMASTER0;
        if (pend_q[sel]) begin
            s_haddr  = paddr_q[sel];
            s_hwrite = pwrite_q[sel];
            s_hsize  = psize_q[sel];
            s_hexcl  = pexcl_q[sel];
        end else begin
            s_haddr  = haddr_in[sel];
            s_hwrite = hwrite_in[sel];
            s_hsize  = hsize_in[sel];
            s_hexcl  = hexcl_in[sel];
        end
    end

    always_comb begin
        down_d   = down_q;
        last_d   = last_q;
        pend_d   = pend_q;
        paddr_d  = paddr_q;
        psize_d  = psize_q;
        pwrite_d = pwrite_q;
        pexcl_d  = pexcl_q;
        if (s_hready_resp) begin
            case (grant)
                2'b01:   down_d = OWN_M0;
                2'b10:   down_d = OWN_M1;
                default: down_d = OWN_NONE;
            endcase
        end
        if (|grant) last_d = grant[1];
        for (int unsigned n = 0; n < 2; n++) begin
            if (grant[n]) begin
                pend_d[n] = 1'b0;
            end else if (live[n]) begin
                pend_d[n]   = 1'b1;
                paddr_d[n]  = haddr_in[n];
                psize_d[n]  = hsize_in[n];
                pwrite_d[n] = hwrite_in[n];
                pexcl_d[n]  = hexcl_in[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_q   <= OWN_NONE;
            last_q   <= 1'b1;
            pend_q   <= '0;
            pwrite_q <= '0;
            pexcl_q  <= '0;
            for (int unsigned n = 0; n < 2; n++) begin
                paddr_q[n] <= '0;
                psize_q[n] <= '0;
            end
        end else begin
            down_q   <= down_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            paddr_q  <= paddr_d;
            psize_q  <= psize_d;
            pwrite_q <= pwrite_d;
            pexcl_q  <= pexcl_d;
        end
    end

    assign s_hready  = s_hready_resp;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    always_comb begin
        m0_hresp   = 1'b0;
        m1_hresp   = 1'b0;
        m0_hexokay = 1'b1;
        m1_hexokay = 1'b1;
        s_hwdata   = '0;
        case (down_q)
            OWN_M0: begin
                m0_hresp   = s_hresp;
                m0_hexokay = s_hexokay;
                s_hwdata   = m0_hwdata;
            end
            OWN_M1: begin
                m1_hresp   = s_hresp;
                m1_hexokay = s_hexokay;
                s_hwdata   = m1_hwdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter with a grant-order scoreboard.
module tb_ahb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
    logic        m0_hwrite, m1_hwrite, m0_hexcl, m1_hexcl;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hexokay, m1_hexokay;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic        s_hwrite, s_hexcl, s_hready, s_hready_resp, s_hresp, s_hexokay;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [7:0]  s_hmaster;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  hm;
    } grant_t;

    grant_t exp_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     k0, k1;

    ahb_mem_arbiter #(.W_ADDR(32), .W_DATA(32), .HMASTER0(8'h00), .HMASTER1(8'h01)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hexcl(m0_hexcl), .m0_htrans(m0_htrans),
        .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m0_hexokay(m0_hexokay), .m0_hrdata(m0_hrdata),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hexcl(m1_hexcl), .m1_htrans(m1_htrans),
        .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .m1_hexokay(m1_hexokay), .m1_hrdata(m1_hrdata),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hexcl(s_hexcl), .s_htrans(s_htrans),
        .s_hsize(s_hsize), .s_hmaster(s_hmaster), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hready_resp(s_hready_resp), .s_hresp(s_hresp), .s_hexokay(s_hexokay), .s_hrdata(s_hrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic [7:0] hm);
        grant_t g;
        g.addr = addr;
        g.hm   = hm;
        exp_q.push_back(g);
    endtask

    task automatic observe(input bit want);
        grant_t e;
        if (want) begin
            chk("grant_htrans", {30'd0, s_htrans}, 32'h2);
            chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant_haddr", s_haddr, e.addr);
                chk("grant_hmaster", {24'd0, s_hmaster}, {24'd0, e.hm});
            end
        end else begin
            chk("idle_htrans", {30'd0, s_htrans}, 32'h0);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_masters();
        m0_htrans = 2'b00; m1_htrans = 2'b00;
        m0_hwrite = 1'b0;  m1_hwrite = 1'b0;
        m0_hexcl  = 1'b0;  m1_hexcl  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_masters();
        m0_haddr = '0; m1_haddr = '0; m0_hsize = 3'b010; m1_hsize = 3'b010;
        m0_hwdata = '0; m1_hwdata = '0;
        s_hready_resp = 1'b1; s_hresp = 1'b1; s_hexokay = 1'b0; s_hrdata = 32'h11223344;

        // Reset values (slave response lines deliberately active)
        next_cycle(); settle();
        chk("rst_m0_hready", {31'd0, m0_hready}, 32'h1);
        chk("rst_m1_hready", {31'd0, m1_hready}, 32'h1);
        chk("rst_m0_hresp", {31'd0, m0_hresp}, 32'h0);
        chk("rst_m1_hresp", {31'd0, m1_hresp}, 32'h0);
        chk("rst_m0_hexokay", {31'd0, m0_hexokay}, 32'h1);
        chk("rst_m1_hexokay", {31'd0, m1_hexokay}, 32'h1);
        chk("rst_htrans", {30'd0, s_htrans}, 32'h0);
        chk("rst_hmaster", {24'd0, s_hmaster}, 32'h0);
        rst_n = 1'b1; s_hresp = 1'b0; s_hexokay = 1'b1;

        // Single master read, zero-latency pass-through
        next_cycle();
        m0_htrans = 2'b10; m0_haddr = 32'h100; push(32'h100, 8'h00);
        settle(); observe(1);
        chk("t1_hsize", {29'd0, s_hsize}, 32'h2);
        chk("t1_m1_hready", {31'd0, m1_hready}, 32'h1);
        next_cycle();
        idle_masters(); s_hready_resp = 1'b0;
        settle(); observe(0);
        chk("t1_m0_hready_stall", {31'd0, m0_hready}, 32'h0);
        chk("t1_m1_hready_stall", {31'd0, m1_hready}, 32'h1);
        chk("t1_hrdata", m0_hrdata, 32'h11223344);
        next_cycle();
        s_hready_resp = 1'b1;
        settle(); observe(0);
        chk("t1_m0_hready_done", {31'd0, m0_hready}, 32'h1);

        // Simultaneous requests after reset: m0 first, m1 replayed
        next_cycle(); do_reset();
        m0_htrans = 2'b10; m0_haddr = 32'h104; m1_htrans = 2'b10; m1_haddr = 32'h204;
        push(32'h104, 8'h00); push(32'h204, 8'h01);
        settle(); observe(1);
        next_cycle();
        m0_htrans = 2'b00; s_hready_resp = 1'b0;
        settle(); observe(0);
        chk("t2_m1_pending", {31'd0, m1_hready}, 32'h0);
        chk("t2_m0_stall", {31'd0, m0_hready}, 32'h0);
        next_cycle();
        s_hready_resp = 1'b1;
        settle(); observe(1);
        chk("t2_m1_still_pending", {31'd0, m1_hready}, 32'h0);
        next_cycle();
        m1_htrans = 2'b00;
        settle(); observe(0);
        chk("t2_m1_hready_done", {31'd0, m1_hready}, 32'h1);

        // Back-to-back from both masters: strict alternation
        next_cycle(); do_reset();
        k0 = 0; k1 = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) next_cycle();
            if (i < 8) begin
                m0_htrans = 2'b10; m0_haddr = 32'h400 + 32'(4 * k0);
                m1_htrans = 2'b10; m1_haddr = 32'h500 + 32'(4 * k1);
            end else begin
                idle_masters();
            end
            if (i % 2 == 0) push(32'h400 + 32'(4 * (i / 2)), 8'h00);
            else            push(32'h500 + 32'(4 * (i / 2)), 8'h01);
            settle(); observe(1);
            if (m0_hready) k0++;
            if (m1_hready) k1++;
        end
        next_cycle(); settle(); observe(0);

        // m1 write parked behind a stalled m0 write data phase
        next_cycle();
        m0_htrans = 2'b10; m0_hwrite = 1'b1; m0_haddr = 32'h300; push(32'h300, 8'h00);
        settle(); observe(1);
        chk("t4_m0_hwrite", {31'd0, s_hwrite}, 32'h1);
        next_cycle();
        m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hwdata = 32'h0BADF00D; s_hready_resp = 1'b0;
        m1_htrans = 2'b10; m1_hwrite = 1'b1; m1_haddr = 32'h200; push(32'h200, 8'h01);
        settle(); observe(0);
        chk("t4_hwdata_m0", s_hwdata, 32'h0BADF00D);
        chk("t4_m1_live", {31'd0, m1_hready}, 32'h1);
        next_cycle();
        s_hready_resp = 1'b1; m1_hwdata = 32'hDEADBEEF; m1_hwrite = 1'b0;
        settle(); observe(1);
        chk("t4_replay_hwrite", {31'd0, s_hwrite}, 32'h1);
        chk("t4_hwdata_still_m0", s_hwdata, 32'h0BADF00D);
        chk("t4_m1_pending", {31'd0, m1_hready}, 32'h0);
        next_cycle();
        idle_masters(); m0_hwdata = 32'h12345678;
        settle(); observe(0);
        chk("t4_hwdata_m1", s_hwdata, 32'hDEADBEEF);
        next_cycle();
        settle();
        chk("t4_hwdata_none", s_hwdata, 32'h0);

        // Exclusive store from m1 that fails
        next_cycle();
        m1_htrans = 2'b10; m1_hwrite = 1'b1; m1_hexcl = 1'b1; m1_haddr = 32'h208; push(32'h208, 8'h01);
        settle(); observe(1);
        chk("t5_hexcl", {31'd0, s_hexcl}, 32'h1);
        next_cycle();
        idle_masters(); s_hexokay = 1'b0; s_hresp = 1'b1;
        settle(); observe(0);
        chk("t5_m1_hexokay", {31'd0, m1_hexokay}, 32'h0);
        chk("t5_m0_hexokay", {31'd0, m0_hexokay}, 32'h1);
        chk("t5_m1_hresp", {31'd0, m1_hresp}, 32'h1);
        chk("t5_m0_hresp", {31'd0, m0_hresp}, 32'h0);
        next_cycle();
        s_hexokay = 1'b1; s_hresp = 1'b0;
        settle(); observe(0);

        // Reset while m0 is pending and m1 owns a stalled data phase
        next_cycle();
        m1_htrans = 2'b10; m1_haddr = 32'h20C; push(32'h20C, 8'h01);
        settle(); observe(1);
        next_cycle();
        m1_htrans = 2'b00; s_hready_resp = 1'b0; m0_htrans = 2'b10; m0_haddr = 32'h10C;
        settle(); observe(0);
        chk("t6_m0_live", {31'd0, m0_hready}, 32'h1);
        next_cycle();
        m1_htrans = 2'b10; m1_haddr = 32'h210; s_hresp = 1'b1; s_hexokay = 1'b0;
        settle();
        chk("t6_m0_pending", {31'd0, m0_hready}, 32'h0);
        chk("t6_m1_stall", {31'd0, m1_hready}, 32'h0);
        s_hready_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_m0_hready", {31'd0, m0_hready}, 32'h1);
        chk("t6_async_m1_hready", {31'd0, m1_hready}, 32'h1);
        chk("t6_async_m1_hresp", {31'd0, m1_hresp}, 32'h0);
        chk("t6_async_m1_hexokay", {31'd0, m1_hexokay}, 32'h1);
        chk("t6_async_htrans", {30'd0, s_htrans}, 32'h0);
        chk("t6_async_hmaster", {24'd0, s_hmaster}, 32'h0);
        next_cycle(); settle();
        chk("t6_rst_m0_hready", {31'd0, m0_hready}, 32'h1);
        chk("t6_rst_htrans", {30'd0, s_htrans}, 32'h0);
        rst_n = 1'b1; idle_masters(); s_hresp = 1'b0; s_hexokay = 1'b1;
        #1; observe(0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle(); observe(0);
        end
        chk("t6_m0_hready_after", {31'd0, m0_hready}, 32'h1);

        chk("sb_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
